// File: rtl/addr_stream_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | addr_stream_gen : address-trace initiator (stride/loop/random/conflict)    |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module addr_stream_gen #(
  parameter int          ADDR_W     = 31,
  parameter int          LINE_SIZE  = 16,
  parameter int          SET_STRIDE = 4096,
  parameter int          CONFLICT_N = 33,
  parameter logic [30:0] LFSR_SEED  = 31'h1ACE5
) (
  input  logic              clk_41,
  input  logic              rst_41,
  input  logic              start_41,
  input  logic [1:0]        mode_41,
  input  logic [ADDR_W-1:0] base_41,
  input  logic [15:0]       stride_41,
  input  logic [ADDR_W-1:0] span_41,
  input  logic [ADDR_W-1:0] count_41,
  output logic [ADDR_W-1:0] addr_41,
  output logic              addr_valid_41,
  input  logic              addr_ready_41,
  output logic              busy_41,
  output logic              done_41,
  output logic [ADDR_W-1:0] issued_41
);

  localparam int                CIDX_W     = (CONFLICT_N > 1) ? $clog2(CONFLICT_N) : 1;
  localparam logic [ADDR_W-1:0] LINE_MASK  = ~ADDR_W'(LINE_SIZE - 1);
  localparam logic [ADDR_W-1:0] SET_STEP   = ADDR_W'(SET_STRIDE);
  localparam logic [CIDX_W-1:0] CIDX_LAST  = CIDX_W'(CONFLICT_N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                valid_q, valid_d;
  logic [ADDR_W-1:0]   issued_q, issued_d;
  logic [1:0]          mode_q, mode_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [15:0]         stride_q, stride_d;
  logic [ADDR_W-1:0]   span_q, span_d;
  logic [ADDR_W-1:0]   count_q, count_d;
  logic [ADDR_W-1:0]   off_q, off_d;
  logic [30:0]         lfsr_q, lfsr_d;
  logic [CIDX_W-1:0]   cidx_q, cidx_d;

  logic                w_xfer;
  logic [ADDR_W-1:0]   w_off_step;
  logic [ADDR_W-1:0]   w_loop_span;
  logic [ADDR_W-1:0]   w_off_wrap;
  logic [30:0]         w_lfsr_step;
  logic [CIDX_W-1:0]   w_cidx_step;
  logic [ADDR_W-1:0]   w_issued_inc;

  // Random-mode offset: LFSR masked to the working set, then line aligned.
  function automatic logic [ADDR_W-1:0] rand_off(input logic [30:0] l,
                                                 input logic [ADDR_W-1:0] sp);
    return (ADDR_W'(l) & (sp - 1'b1)) & LINE_MASK;
  endfunction

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    valid_d  = valid_q;
    issued_d = issued_q;
    mode_d   = mode_q;
    base_d   = base_q;
    stride_d = stride_q;
    span_d   = span_q;
    count_d  = count_q;
    off_d    = off_q;
    lfsr_d   = lfsr_q;
    cidx_d   = cidx_q;

    w_xfer       = valid_q & addr_ready_41;
    w_issued_inc = issued_q + 1'b1;
    w_off_step   = off_q + ADDR_W'(stride_q);
    w_loop_span  = (span_q == '0) ? ADDR_W'(stride_q) : span_q;
    w_off_wrap   = (w_off_step >= w_loop_span) ? (w_off_step - w_loop_span) : w_off_step;
    w_lfsr_step  = {lfsr_q[29:0], lfsr_q[30] ^ lfsr_q[27]};
    w_cidx_step  = (cidx_q == CIDX_LAST) ? '0 : (cidx_q + 1'b1);

    unique case (state_q)
      S_IDLE: begin
        if (start_41) begin
          mode_d   = mode_41;
          base_d   = base_41;
          stride_d = stride_41;
          span_d   = span_41;
          count_d  = count_41;
          issued_d = '0;
          off_d    = '0;
          cidx_d   = '0;
          if (count_41 == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
            valid_d = 1'b1;
            addr_d  = (mode_41 == 2'd2) ? (base_41 + rand_off(lfsr_q, span_41)) : base_41;
          end
        end
      end
      S_RUN: begin
        if (w_xfer) begin
          issued_d = w_issued_inc;
          unique case (mode_q)
            2'd0: begin
              off_d  = w_off_step;
              addr_d = base_q + w_off_step;
            end
            2'd1: begin
              off_d  = w_off_wrap;
              addr_d = base_q + w_off_wrap;
            end
            2'd2: begin
              lfsr_d = w_lfsr_step;
              addr_d = base_q + rand_off(w_lfsr_step, span_q);
            end
            default: begin
              cidx_d = w_cidx_step;
              addr_d = base_q + ADDR_W'(w_cidx_step) * SET_STEP;
            end
          endcase
          if (w_issued_inc == count_q) begin
            state_d = S_DONE;
            valid_d = 1'b0;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_41) begin
    if (rst_41) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      valid_q  <= 1'b0;
      issued_q <= '0;
      mode_q   <= '0;
      base_q   <= '0;
      stride_q <= '0;
      span_q   <= '0;
      count_q  <= '0;
      off_q    <= '0;
      lfsr_q   <= LFSR_SEED;
      cidx_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      valid_q  <= valid_d;
      issued_q <= issued_d;
      mode_q   <= mode_d;
      base_q   <= base_d;
      stride_q <= stride_d;
      span_q   <= span_d;
      count_q  <= count_d;
      off_q    <= off_d;
      lfsr_q   <= lfsr_d;
      cidx_q   <= cidx_d;
    end
  end

  assign addr_41       = addr_q;
  assign addr_valid_41 = valid_q;
  assign busy_41       = (state_q == S_RUN);
  assign done_41       = (state_q == S_DONE);
  assign issued_41     = issued_q;

endmodule
`default_nettype wire

// File: tb/tb_addr_stream_gen.sv
`default_nettype none
// Scoreboard bench for addr_stream_gen: expected addresses queued at start, popped per transfer.
module tb_addr_stream_gen;

  localparam logic [30:0] SEED = 31'h1ACE5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = '0;
  logic [30:0] base = '0;
  logic [15:0] stride = '0;
  logic [30:0] span = '0;
  logic [30:0] count = '0;
  logic [30:0] addr;
  logic        addr_valid;
  logic        addr_ready = 1'b1;
  logic        busy;
  logic        done;
  logic [30:0] issued;

  int          errors = 0;
  int          checks = 0;
  logic [30:0] exp_q[$];
  logic [30:0] m_lfsr = SEED;
  int          rdy_mode = 0;
  logic        ready_man = 1'b1;
  int          n_xfer = 0;
  logic        chk_rand = 1'b0;
  logic        save_en = 1'b0;
  logic        cmp_saved = 1'b0;
  logic [30:0] saved[50];

  addr_stream_gen dut (
    .clk_41        (clk),
    .rst_41        (rst),
    .start_41      (start),
    .mode_41       (mode),
    .base_41       (base),
    .stride_41     (stride),
    .span_41       (span),
    .count_41      (count),
    .addr_41       (addr),
    .addr_valid_41 (addr_valid),
    .addr_ready_41 (addr_ready),
    .busy_41       (busy),
    .done_41       (done),
    .issued_41     (issued)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Ready driver: 0 = always high, 1 = random, 2 = manual level.
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      1:       addr_ready = 1'($urandom_range(0, 1));
      2:       addr_ready = ready_man;
      default: addr_ready = 1'b1;
    endcase
  end

  // A transfer happens at the next rising edge when valid & ready are seen here.
  always @(negedge clk) begin
    if (!rst && addr_valid && addr_ready) begin
      n_xfer++;
      if (exp_q.size() == 0) begin
        chk("unexpected_xfer", 32'(addr), 32'h7FFF_FFFF);
      end else begin
        chk("addr", 32'(addr), 32'(exp_q.pop_front()));
      end
      if (chk_rand) begin
        chk("rand_range", 32'((addr - 31'h4000) < 31'd1024), 32'd1);
        chk("rand_align", 32'(addr[3:0]), 32'd0);
      end
      if (save_en && n_xfer <= 50) saved[n_xfer-1] = addr;
      if (cmp_saved && n_xfer <= 50) chk("rerun_vs_first", 32'(addr), 32'(saved[n_xfer-1]));
    end
  end

  task automatic model_push(input logic [1:0] m, input logic [30:0] b, input logic [15:0] s,
                            input logic [30:0] sp, input logic [30:0] c);
    logic [30:0] off;
    logic [30:0] eff;
    int          ci;
    off = '0;
    ci  = 0;
    eff = (sp == 0) ? 31'(s) : sp;
    for (int k = 0; k < int'(c); k++) begin
      case (m)
        2'd0: begin
          exp_q.push_back(b + off);
          off = off + 31'(s);
        end
        2'd1: begin
          exp_q.push_back(b + off);
          off = off + 31'(s);
          if (off >= eff) off = off - eff;
        end
        2'd2: begin
          exp_q.push_back(b + ((m_lfsr & (sp - 31'd1)) & ~31'd15));
          m_lfsr = {m_lfsr[29:0], m_lfsr[30] ^ m_lfsr[27]};
        end
        default: begin
          exp_q.push_back(b + 31'(ci) * 31'd4096);
          ci = (ci == 32) ? 0 : ci + 1;
        end
      endcase
    end
  endtask

  // Returns one cycle after the start edge, i.e. when the first address should be up.
  task automatic start_run(input logic [1:0] m, input logic [30:0] b, input logic [15:0] s,
                           input logic [30:0] sp, input logic [30:0] c);
    @(posedge clk);
    #1;
    mode = m; base = b; stride = s; span = sp; count = c; start = 1'b1;
    n_xfer = 0;
    model_push(m, b, s, sp, c);
    @(posedge clk);
    #1;
    start = 1'b0;
    mode = 2'($urandom); base = 31'($urandom); count = 31'($urandom);
    chk("valid_after_start", 32'(addr_valid), (c != 0) ? 32'd1 : 32'd0);
    chk("issued_cleared", 32'(issued), 32'd0);
  endtask

  task automatic finish_run(input int exp_cyc, input logic [30:0] c);
    int cyc;
    cyc = 0;
    while (!done && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("done_seen", 32'(done), 32'd1);
    if (exp_cyc >= 0) chk("done_latency", 32'(cyc), 32'(exp_cyc));
    chk("issued_final", 32'(issued), 32'(c));
    chk("valid_in_done", 32'(addr_valid), 32'd0);
    chk("busy_in_done", 32'(busy), 32'd0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("issued_held", 32'(issued), 32'(c));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_valid", 32'(addr_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_issued", 32'(issued), 32'd0);
    rst = 1'b0;

    // T1 stride
    start_run(2'd0, 31'h100, 16'd16, 31'd0, 31'd4);
    chk("t1_first_addr", 32'(addr), 32'h100);
    finish_run(4, 31'd4);

    // T2 loop
    start_run(2'd1, 31'h0, 16'd64, 31'd192, 31'd7);
    finish_run(7, 31'd7);

    // T3 back-pressure on the second address
    start_run(2'd0, 31'h0, 16'd4, 31'd0, 31'd3);
    @(posedge clk);
    #1;
    rdy_mode = 2; ready_man = 1'b0;
    chk("t3_second_addr", 32'(addr), 32'h4);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("t3_hold_addr", 32'(addr), 32'h4);
      chk("t3_hold_issued", 32'(issued), 32'd1);
      chk("t3_hold_valid", 32'(addr_valid), 32'd1);
    end
    rdy_mode = 0;
    finish_run(-1, 31'd3);

    // T4 conflict set cycling
    start_run(2'd3, 31'h20, 16'd0, 31'd0, 31'd35);
    finish_run(35, 31'd35);

    // T5 zero-length run
    start_run(2'd0, 31'h0, 16'd0, 31'd0, 31'd0);
    chk("t5_done_at_start1", 32'(done), 32'd1);
    finish_run(0, 31'd0);

    // T6 random with mid-run reset
    chk_rand = 1'b1; save_en = 1'b1;
    start_run(2'd2, 31'h4000, 16'd0, 31'd1024, 31'd100);
    for (int i = 0; i < 500 && n_xfer < 50; i++) @(posedge clk);
    chk("t6_reached_50", 32'(n_xfer >= 50), 32'd1);
    #1;
    rst = 1'b1; save_en = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_rst_addr", 32'(addr), 32'd0);
    chk("t6_rst_valid", 32'(addr_valid), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);
    chk("t6_rst_issued", 32'(issued), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    m_lfsr = SEED;
    @(posedge clk);
    #1;
    chk("t6_no_done_after_abort", 32'(done), 32'd0);
    cmp_saved = 1'b1;
    start_run(2'd2, 31'h4000, 16'd0, 31'd1024, 31'd50);
    finish_run(50, 31'd50);
    cmp_saved = 1'b0;
    start_run(2'd2, 31'h4000, 16'd0, 31'd1024, 31'd20);
    finish_run(20, 31'd20);
    chk_rand = 1'b0;

    // Loop mode near the top of the address space with random back-pressure
    rdy_mode = 1;
    start_run(2'd1, 31'h7FFF_FFE0, 16'd48, 31'd100, 31'd20);
    finish_run(-1, 31'd20);
    rdy_mode = 0;

    // Stride wrap modulo 2^31
    start_run(2'd0, 31'h7FFF_FFF0, 16'd16, 31'd0, 31'd3);
    finish_run(3, 31'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
